// File: rtl/sliding_pattern_detector_pkg.sv
// Shared state encodings and default geometry for the sliding-window detector family.
package sliding_pattern_detector_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } det_state_e;

  localparam int         DEF_LEN   = 8;
  localparam int         DEF_CNT_W = 8;
  localparam logic [7:0] DEF_PAT   = 8'b1100_1001;

endpackage

// File: rtl/sliding_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with increment yields 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/sliding_pattern_detector.sv
// Programmable serial pattern detector: LEN-bit sliding window, per-bit mask,
// overlapping/non-overlapping modes and a saturating match counter.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_FILL  | fewer than LEN-1 valid bits since reset/reconfig/last match
//   ST_ARMED | LEN-1 bits held; the next valid bit completes a full window
module sliding_pattern_detector
  import sliding_pattern_detector_pkg::*;
#(
  parameter int             LEN         = DEF_LEN,
  parameter int             CNT_W       = DEF_CNT_W,
  parameter logic [LEN-1:0] DEFAULT_PAT = LEN'(DEF_PAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_we,
  input  logic [LEN-1:0]   cfg_pattern,
  input  logic [LEN-1:0]   cfg_mask,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             dec,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int            FW       = $clog2(LEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(LEN - 1);

  det_state_e     state_q, state_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic [LEN-2:0] hist_q, hist_d;
  logic [LEN-1:0] pat_q, pat_d;
  logic [LEN-1:0] mask_q, mask_d;
  logic           overlap_q, overlap_d;
  logic [LEN-1:0] window;
  logic           hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FILL;
      fill_q    <= '0;
      hist_q    <= '0;
      pat_q     <= DEFAULT_PAT;
      mask_q    <= '1;
      overlap_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      hist_q    <= hist_d;
      pat_q     <= pat_d;
      mask_q    <= mask_d;
      overlap_q <= overlap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    hist_d    = hist_q;
    pat_d     = pat_q;
    mask_d    = mask_q;
    overlap_d = overlap_q;
    dec       = 1'b0;
    window    = {hist_q, in_bit};
    hit       = (((window ^ pat_q) & mask_q) == '0);

    // Reconfiguration takes priority and discards the bit on in_bit.
    if (cfg_we) begin
      pat_d     = cfg_pattern;
      mask_d    = cfg_mask;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
      state_d   = ST_FILL;
    end else if (in_valid) begin
      hist_d = window[LEN-2:0];
      case (state_q)
        ST_FILL: begin
          fill_d = fill_q + FW'(1);
          if (fill_q == FILL_MAX - FW'(1)) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          dec = hit;
          // Non-overlapping: the history keeps shifting but needs LEN fresh bits.
          if (hit && !overlap_q) begin
            fill_d  = '0;
            state_d = ST_FILL;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  assign armed = (state_q == ST_ARMED);

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (dec),
    .clr   (cnt_clr),
    .count (match_cnt)
  );

endmodule

// File: tb/tb_sliding_pattern_detector.sv
// Directed bench for sliding_pattern_detector: queue-based window model checked every
// cycle, plus literal per-bit expectations from the stimulus tables.
module tb_sliding_pattern_detector;
  localparam int LEN = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0, in_bit = 1'b0, cfg_we = 1'b0, cfg_overlap = 1'b1, cnt_clr = 1'b0;
  logic [LEN-1:0] cfg_pattern = '0, cfg_mask = '0;
  logic           dec, armed, dec2, armed2;
  logic [7:0]     match_cnt;
  logic [1:0]     match_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sliding_pattern_detector #(.LEN(LEN), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .dec(dec), .match_cnt(match_cnt), .armed(armed));

  sliding_pattern_detector #(.LEN(LEN), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .dec(dec2), .match_cnt(match_cnt2), .armed(armed2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the valid bits since the last resync, newest last, capped at LEN.
  bit         q[$];
  bit         tmp[$];
  logic [7:0] m_pat = 8'hC9, m_mask = 8'hFF;
  bit         m_ov = 1'b1;
  int         m_cnt8 = 0, m_cnt2 = 0;
  bit         e_dec;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_pat = 8'hC9; m_mask = 8'hFF; m_ov = 1'b1; m_cnt8 = 0; m_cnt2 = 0;
      check("rst_dec", dec, 0);
      check("rst_armed", armed, 0);
      check("rst_cnt", match_cnt, 0);
    end else begin
      e_dec = 1'b0;
      tmp = q;
      if (in_valid && !cfg_we) begin
        tmp.push_back(in_bit);
        if (tmp.size() > LEN) void'(tmp.pop_front());
        if (tmp.size() == LEN) begin
          e_dec = 1'b1;
          for (int i = 0; i < LEN; i++)
            if (m_mask[i] && (tmp[LEN-1-i] != m_pat[i])) e_dec = 1'b0;
        end
      end
      check("m_dec", dec, e_dec);
      check("m_dec2", dec2, e_dec);
      check("m_armed", armed, (q.size() >= LEN - 1));
      check("m_armed2", armed2, (q.size() >= LEN - 1));
      check("m_cnt8", match_cnt, m_cnt8);
      check("m_cnt2", match_cnt2, m_cnt2);
      if (cfg_we) begin
        q.delete();
        m_pat = cfg_pattern; m_mask = cfg_mask; m_ov = cfg_overlap;
      end else if (in_valid) begin
        q = tmp;
        if (e_dec && !m_ov) q.delete();
      end
      if (cnt_clr) begin
        m_cnt8 = e_dec; m_cnt2 = e_dec;
      end else if (e_dec) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  end

  // bits[n-1] is sent first; exp[i] is the literal dec for bits[i]; gaps[i] inserts an idle cycle before it.
  task automatic send_bits(input string name, input logic [31:0] bits, input int n,
                           input logic [31:0] exp, input logic [31:0] gaps);
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps[i]) begin
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
        #2 check({name, "_gap"}, dec, 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b1; in_bit = bits[i]; cfg_we = 1'b0; cnt_clr = 1'b0;
      #2 check(name, dec, exp[i]);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
    #2;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [7:0] m, input logic ov);
    @(posedge clk); #1;
    cfg_we = 1'b1; in_valid = 1'b1; in_bit = 1'b1; cnt_clr = 1'b0;
    cfg_pattern = p; cfg_mask = m; cfg_overlap = ov;
    #2 check("cfg_dec", dec, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    check("t1_armed0", armed, 0);
    check("t1_cnt0", match_cnt, 0);

    // 1: default pattern after reset
    send_bits("t1_dec", 32'b1100_1001, 8, 32'b0000_0001, 32'h0);
    idle();
    check("t1_cnt", match_cnt, 1);
    check("t1_cnt2", match_cnt2, 1);

    // 2: overlapping vs non-overlapping
    cfg(8'hAA, 8'hFF, 1'b1);
    send_bits("t2_ov1", 32'b10_1010_1010, 10, 32'b00_0000_0101, 32'h0);
    cfg(8'hAA, 8'hFF, 1'b0);
    send_bits("t2_ov0", 32'b10_1010_1010, 10, 32'b00_0000_0100, 32'h0);

    // 3: masked compare
    cfg(8'b1100_0000, 8'hF0, 1'b1);
    send_bits("t3_hit", 32'b1100_0110, 8, 32'b0000_0001, 32'h0);
    cfg(8'b1100_0000, 8'hF0, 1'b1);
    send_bits("t3_miss", 32'b1000_0110, 8, 32'b0000_0000, 32'h0);

    // 4: gaps, then a reconfig that would otherwise have completed a match
    cfg(8'hC9, 8'hFF, 1'b1);
    send_bits("t4_gap", 32'b1100_1001, 8, 32'b0000_0001, 32'b0010_0100);
    send_bits("t4_pre", 32'b110_0100, 7, 32'h0, 32'h0);
    cfg(8'hC9, 8'hFF, 1'b1);
    send_bits("t4_post", 32'b1001_1100_1001, 12, 32'b0000_0000_0001, 32'h0);

    // 5: saturation with mask=0, then clear coinciding with a match
    @(posedge clk); #1;
    in_valid = 1'b0; cnt_clr = 1'b1;
    idle();
    check("t5_clr", match_cnt, 0);
    cfg(8'h00, 8'h00, 1'b1);
    send_bits("t5_any", 32'b0110_1001_0011, 12, 32'b0000_0001_1111, 32'h0);
    idle();
    check("t5_cnt8", match_cnt, 5);
    check("t5_sat2", match_cnt2, 3);
    @(posedge clk); #1;
    in_valid = 1'b1; in_bit = 1'b0; cnt_clr = 1'b1;
    #2 check("t5_cdec", dec, 1);
    idle();
    check("t5_clrinc", match_cnt, 1);
    check("t5_clrinc2", match_cnt2, 1);

    // 6: asynchronous reset in the middle of a window
    cfg(8'hC9, 8'hFF, 1'b1);
    send_bits("t6_pre", 32'b1_1001_0011_1001, 13, 32'b0_0000_0010_0000, 32'h0);
    #1 check("t6_armed", armed, 1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_bit = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6_dec", dec, 0);
    check("t6_armed0", armed, 0);
    check("t6_cnt", match_cnt, 0);
    check("t6_cnt2", match_cnt2, 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    send_bits("t6_post", 32'b01_1100_1001, 10, 32'b00_0000_0001, 32'h0);
    idle();
    check("t6_cntend", match_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
